// File: rtl/lock_pkg.sv
// Shared constants and press classification for the button combination-lock front end.
package lock_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int BTN0 = 0;
    localparam int BTN1 = 1;

    typedef enum logic [1:0] {
        PRESS_NONE = 2'b00,
        PRESS_0    = 2'b01,
        PRESS_1    = 2'b10,
        PRESS_BOTH = 2'b11
    } press_e;

    // Bit BTN0 of rise is button 0, bit BTN1 is button 1.
    function automatic press_e classify_press(input logic [1:0] rise);
        press_e kind;
        kind = PRESS_NONE;
        unique case (rise)
            2'b01:   kind = PRESS_0;
            2'b10:   kind = PRESS_1;
            2'b11:   kind = PRESS_BOTH;
            default: kind = PRESS_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: two-flop synchroniser followed by a stable-count debouncer.
module debounce_chan
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_p0;
    logic             s2_p1;
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    // Synchroniser stages, then the counter compares the settled sample against the held level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_p0 <= 1'b0;
            s2_p1 <= 1'b0;
            cnt   <= '0;
            lvl   <= 1'b0;
        end else begin
            s1_p0 <= raw;
            s2_p1 <= s1_p0;
            if (s2_p1 == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                lvl <= s2_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = lvl;

endmodule

// File: rtl/button_debounce_pulse.sv
// Debounces two raw buttons and turns accepted presses into single-cycle pulses,
// collapsing same-edge double presses into a conflict pulse.
module button_debounce_pulse
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_0,
    input  logic btn_raw_1,
    output logic button_0,
    output logic button_1,
    output logic btn_level_0,
    output logic btn_level_1,
    output logic conflict
);

    logic [1:0] lvl;
    logic [1:0] lvl_prev;
    logic [1:0] rise;
    press_e     press;

    debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan0 (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw_0),
        .level (lvl[BTN0])
    );

    debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan1 (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_raw_1),
        .level (lvl[BTN1])
    );

    assign rise  = lvl & ~lvl_prev;
    assign press = classify_press(rise);

    // Edge detect stage: releases and held levels produce no rise, so no pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_prev <= 2'b00;
            button_0 <= 1'b0;
            button_1 <= 1'b0;
            conflict <= 1'b0;
        end else begin
            lvl_prev <= lvl;
            button_0 <= (press == PRESS_0);
            button_1 <= (press == PRESS_1);
            conflict <= (press == PRESS_BOTH);
        end
    end

    assign btn_level_0 = lvl[BTN0];
    assign btn_level_1 = lvl[BTN1];

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed vector bench for button_debounce_pulse with DEBOUNCE_CYCLES = 4.
module tb_button_debounce_pulse;

    logic clk;
    logic rst;
    logic btn_raw_0;
    logic btn_raw_1;
    logic button_0;
    logic button_1;
    logic btn_level_0;
    logic btn_level_1;
    logic conflict;

    typedef struct {
        int         grp;
        logic       rst;
        logic       raw0;
        logic       raw1;
        logic [4:0] exp;   // {button_0, button_1, btn_level_0, btn_level_1, conflict}
    } vec_t;

    vec_t vecs[$];
    int   nvec;
    int   nerr;
    int   grp;

    button_debounce_pulse #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw_0   (btn_raw_0),
        .btn_raw_1   (btn_raw_1),
        .button_0    (button_0),
        .button_1    (button_1),
        .btn_level_0 (btn_level_0),
        .btn_level_1 (btn_level_1),
        .conflict    (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {button_0, button_1, btn_level_0, btn_level_1, conflict};
    endfunction

    task automatic add(input int n, input logic rs, input logic r0, input logic r1,
                       input logic b0, input logic b1, input logic l0, input logic l1,
                       input logic c);
        vec_t v;
        v.grp  = grp;
        v.rst  = rs;
        v.raw0 = r0;
        v.raw1 = r1;
        v.exp  = {b0, b1, l0, l1, c};
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    initial begin
        logic [7:0] bounce;
        int         pulses;
        int         pulse_at;
        int         confs;
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        btn_raw_0 = 1'b0;
        btn_raw_1 = 1'b0;
        #1;
        check("reset_state", {27'd0, outs()}, 32'd0);

        // 1: reset with toggling raws, then idle
        grp = 1;
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(4, 0, 0, 0, 0, 0, 0, 0, 0);
        // 2: button 0 press, hold, release
        grp = 2;
        add(5, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1, 0, 0);
        add(5, 0, 1, 0, 0, 0, 1, 0, 0);
        add(5, 0, 0, 0, 0, 0, 1, 0, 0);
        add(3, 0, 0, 0, 0, 0, 0, 0, 0);
        // 3: button 1 bounces, then holds
        grp = 3;
        bounce = 8'b1110_1110;
        for (int i = 7; i >= 0; i--) add(1, 0, 0, bounce[i], 0, 0, 0, 0, 0);
        add(5, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 0, 1, 0, 1, 0);
        add(3, 0, 0, 1, 0, 0, 0, 1, 0);
        add(5, 0, 0, 0, 0, 0, 0, 1, 0);
        add(3, 0, 0, 0, 0, 0, 0, 0, 0);
        // 4: simultaneous press
        grp = 4;
        add(5, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 1, 1, 0);
        add(1, 0, 1, 1, 0, 0, 1, 1, 1);
        add(1, 0, 1, 1, 0, 0, 1, 1, 0);
        add(5, 0, 0, 0, 0, 0, 1, 1, 0);
        add(3, 0, 0, 0, 0, 0, 0, 0, 0);
        // 5: staggered by one cycle
        grp = 5;
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(4, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 1, 0, 0);
        add(1, 0, 1, 1, 1, 0, 1, 1, 0);
        add(1, 0, 1, 1, 0, 1, 1, 1, 0);
        add(2, 0, 1, 1, 0, 0, 1, 1, 0);
        add(5, 0, 0, 0, 0, 0, 1, 1, 0);
        add(3, 0, 0, 0, 0, 0, 0, 0, 0);
        // 6: reset pulse while button 0 held
        grp = 6;
        add(3, 0, 1, 0, 0, 0, 0, 0, 0);
        add(2, 1, 1, 0, 0, 0, 0, 0, 0);
        add(5, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1, 0, 0);
        add(3, 0, 1, 0, 0, 0, 1, 0, 0);

        @(negedge clk);
        foreach (vecs[k]) begin
            rst       = vecs[k].rst;
            btn_raw_0 = vecs[k].raw0;
            btn_raw_1 = vecs[k].raw1;
            @(posedge clk);
            @(negedge clk);
            nvec++;
            if (outs() !== vecs[k].exp) begin
                nerr++;
                $display("FAIL vec %0d grp %0d: got b0,b1,l0,l1,c=%b want %b",
                         k, vecs[k].grp, outs(), vecs[k].exp);
            end
        end

        // Asynchronous reset clears the level mid-cycle without a clock edge.
        check("pre_async_level", {31'd0, btn_level_0}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outs", {27'd0, outs()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Long hold after reset: exactly one pulse, D+2 edges after reset release.
        pulses = 0;
        pulse_at = -1;
        confs = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (button_0) begin
                pulses++;
                pulse_at = k;
            end
            if (conflict || button_1) confs++;
        end
        check("held_pulse_count", pulses, 32'd1);
        check("held_pulse_edge", pulse_at, 32'd6);
        check("held_no_other", confs, 32'd0);

        // Release is accepted within a bounded number of cycles and never pulses.
        btn_raw_0 = 1'b0;
        pulses = 0;
        pulse_at = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (button_0 || button_1 || conflict) pulses++;
            if (!btn_level_0 && pulse_at < 0) pulse_at = k;
        end
        check("release_edge", pulse_at, 32'd5);
        check("release_no_pulse", pulses, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
